parking_gate_sensor_fsm: RTL and testbench
==========================================

Name: parking_gate_sensor_fsm

Overview:
- Stimulus-side producer for the team's counter chain: converts two raw photo-sensor levels (outer A, inner B) into single-cycle Increase/Decrease pulses that drive the Start0 counter cascade.
- Consumes asynchronous sensor levels and emits clean, registered, one-cycle pulses on the counter's Increase input (and its Decrease twin).
- Full entry/exit sequences only; partial passes, reversals and illegal jumps are filtered out.

Parameters:
- FILTER_CYCLES, 4, consecutive stable synchronized samples required before a sensor change is accepted (used only with GLITCH_FILTER_EN; legal 1..255).

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- SensorA  input  1  outer sensor, 1 = beam blocked, asynchronous to Clock.
- SensorB  input  1  inner sensor, 1 = beam blocked, asynchronous to Clock.
- Increase  output  1  one-cycle pulse per completed entry.
- Decrease  output  1  one-cycle pulse per completed exit.
- SeqError  output  1  one-cycle pulse on an illegal sensor transition.
- Busy  output  1  high while a sequence is in progress (state != IDLE), registered.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; Increase=Decrease=SeqError=Busy=0; synchronizer and filter flops cleared to 0. Outputs stay 0 for the first cycle after release.
- Input path: each sensor goes through a 2-flop synchronizer, giving a_s, b_s. The FSM samples code {a_s,b_s}.
- All outputs are registered. A raw change set up before edge k is seen by the FSM at edge k+2. Any resulting pulse is high from edge k+2 to edge k+3.
- States: IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
- IDLE:
  - 00 or 11 -> stay. On 11, pulse SeqError.
  - 10 -> EN1.
  - 01 -> EX1.
- EN1 (A only):
  - 10 -> stay.
  - 11 -> EN2.
  - 00 -> IDLE, silent abort.
  - 01 -> IDLE with SeqError.
- EN2 (both):
  - 11 -> stay.
  - 01 -> EN3.
  - 10 -> EN1 (backtrack).
  - 00 -> IDLE with SeqError.
- EN3 (B only):
  - 01 -> stay.
  - 00 -> IDLE with Increase pulse.
  - 11 -> EN2 (backtrack).
  - 10 -> IDLE with SeqError.
- EX1..EX3 mirror EN1..EN3 with A and B swapped. Completion (EX3, 00) -> IDLE with Decrease pulse.
- Pulse rules:
  - Increase, Decrease and SeqError are mutually exclusive and never high two consecutive cycles.
  - A held 00 produces no further pulses.
  - A new sequence may begin in the cycle after a completion pulse.
- Busy = 1 exactly when the registered state is not IDLE.
- Reset mid-sequence: immediate return to IDLE; no pulse is emitted; a partial sequence is discarded.
- State encoding is an implementation choice. Unused codes recover to IDLE on the next edge, with no pulse.

Optional Feature:
- GLITCH_FILTER_EN defined:
  - Per-sensor 8-bit stability counter after the synchronizer.
  - The filtered value updates only after the synchronized value differs from it for FILTER_CYCLES consecutive cycles. The counter clears on any bounce.
  - Latency from raw change to FSM becomes 2+FILTER_CYCLES edges.
- GLITCH_FILTER_EN undefined: no filter logic is generated; FSM consumes a_s, b_s directly; FILTER_CYCLES is ignored.

Test Plan:
- Entry: Reset low 2 cycles then high; drive AB=00,10,11,01,00, each held 4 cycles -> exactly one Increase pulse, 3 edges after the final 00; Decrease=SeqError=0; Busy high from the first 10 seen until the pulse cycle.
- Exit: AB=01,11,10,00, each held 4 cycles -> exactly one Decrease pulse; Increase=0.
- Abort and backtrack: 10,00 -> no pulse, Busy returns 0. Then 10,11,01,11,01,00 -> exactly one Increase.
- Illegal jump: 10 then directly 01 -> one SeqError pulse, state IDLE, Busy=0. A following 01,11,10,00 -> one Decrease.
- Reset mid-operation: 10,11, then assert Reset asynchronously between edges -> all outputs 0 immediately. Release and drive 01,00 -> no Increase (fresh EX1 abort), no pulse at all.
- With GLITCH_FILTER_EN and FILTER_CYCLES=4: 1-cycle and 3-cycle pulses on SensorA -> no state change and no pulses. A 5-cycle 10 -> Busy rises 6 edges after the raw change.

Source files
------------

// File: rtl/parking_gate_sensor_fsm_if.sv
// Sensor inputs and pulse outputs of the parking gate sequencer.
// The master drives the sensor levels; the slave (the FSM) returns the pulses.
interface parking_gate_sensor_fsm_if;
    logic SensorA;
    logic SensorB;
    logic Increase;
    logic Decrease;
    logic SeqError;
    logic Busy;

    modport master (
        output SensorA, SensorB,
        input  Increase, Decrease, SeqError, Busy
    );

    modport slave (
        input  SensorA, SensorB,
        output Increase, Decrease, SeqError, Busy
    );
endinterface

// File: rtl/parking_gate_sensor_fsm.sv
// Turns two raw beam sensors (outer A, inner B) into clean one-cycle entry/exit/error pulses.
// Optional per-sensor stability filter enabled with `define GLITCH_FILTER_EN.
module parking_gate_sensor_fsm #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic                        Clock,
    input  logic                        Reset,
    parking_gate_sensor_fsm_if.slave    bus
);

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter_cycles
        $error("FILTER_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } state_e;

    logic [1:0] a_sync_q, b_sync_q;
    logic       a_s, b_s;
    logic [1:0] code;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_sync_q <= 2'b00;
            b_sync_q <= 2'b00;
        end else begin
            a_sync_q <= {a_sync_q[0], bus.SensorA};
            b_sync_q <= {b_sync_q[0], bus.SensorB};
        end
    end

    assign a_s = a_sync_q[1];
    assign b_s = b_sync_q[1];

`ifdef GLITCH_FILTER_EN
    localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

    logic [1:0]      sync_ab;
    logic [1:0]      flt_q, flt_d;
    logic [1:0][7:0] cnt_q, cnt_d;

    assign sync_ab = {a_s, b_s};

    // A sensor's filtered level moves only after FILTER_CYCLES back-to-back disagreeing samples.
    always_comb begin
        flt_d = flt_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_ab[i] == flt_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_LAST) begin
                flt_d[i] = sync_ab[i];
                cnt_d[i] = 8'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            flt_q <= 2'b00;
            cnt_q <= '0;
        end else begin
            flt_q <= flt_d;
            cnt_q <= cnt_d;
        end
    end

    assign code = flt_q;
`else
    assign code = {a_s, b_s};
`endif

    state_e     state_q, state_d;
    logic [1:0] code_q;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            code_q  <= 2'b00;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                case (code)
                    2'b10:   state_d = EN1;
                    2'b01:   state_d = EX1;
                    default: state_d = IDLE;
                endcase
            end
            EN1: begin
                case (code)
                    2'b10:   state_d = EN1;
                    2'b11:   state_d = EN2;
                    default: state_d = IDLE;
                endcase
            end
            EN2: begin
                case (code)
                    2'b11:   state_d = EN2;
                    2'b01:   state_d = EN3;
                    2'b10:   state_d = EN1;
                    default: state_d = IDLE;
                endcase
            end
            EN3: begin
                case (code)
                    2'b01:   state_d = EN3;
                    2'b11:   state_d = EN2;
                    default: state_d = IDLE;
                endcase
            end
            EX1: begin
                case (code)
                    2'b01:   state_d = EX1;
                    2'b11:   state_d = EX2;
                    default: state_d = IDLE;
                endcase
            end
            EX2: begin
                case (code)
                    2'b11:   state_d = EX2;
                    2'b10:   state_d = EX3;
                    2'b01:   state_d = EX1;
                    default: state_d = IDLE;
                endcase
            end
            EX3: begin
                case (code)
                    2'b10:   state_d = EX3;
                    2'b11:   state_d = EX2;
                    default: state_d = IDLE;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle-on-11 flags only the first cycle of a fresh 11, and never right after another pulse,
    // so a held illegal code cannot stream SeqError.
    always_comb begin
        inc_d  = 1'b0;
        dec_d  = 1'b0;
        err_d  = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: err_d = (code == 2'b11) && (code_q != 2'b11) && !(inc_q || dec_q || err_q);
            EN1:  err_d = (code == 2'b01);
            EN2:  err_d = (code == 2'b00);
            EN3: begin
                inc_d = (code == 2'b00);
                err_d = (code == 2'b10);
            end
            EX1:  err_d = (code == 2'b10);
            EX2:  err_d = (code == 2'b00);
            EX3: begin
                dec_d = (code == 2'b00);
                err_d = (code == 2'b01);
            end
            default: ;
        endcase
    end

    assign bus.Increase = inc_q;
    assign bus.Decrease = dec_q;
    assign bus.SeqError = err_q;
    assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_parking_gate_sensor_fsm.sv
// Directed bench for parking_gate_sensor_fsm: table of held sensor codes plus timing sequences.
module tb_parking_gate_sensor_fsm;

`ifdef GLITCH_FILTER_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif
    localparam int HOLD = 8;
    localparam int NV   = 38;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    parking_gate_sensor_fsm_if bus();

    parking_gate_sensor_fsm #(.FILTER_CYCLES(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic a;
        logic b;
        int   inc;
        int   dec;
        int   err;
        logic busy;
    } vec_t;

    vec_t tbl [NV];
    int   checks = 0;
    int   errors = 0;
    int   n_inc, n_dec, n_err;
    logic busy_seen;
    logic prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [2:0] p;
        @(posedge Clock);
        #1;
        p = {bus.Increase, bus.Decrease, bus.SeqError};
        n_inc += int'(bus.Increase);
        n_dec += int'(bus.Decrease);
        n_err += int'(bus.SeqError);
        busy_seen = busy_seen | bus.Busy;
        check("pulse_one_hot", 32'($countones(p) <= 1), 32'd1);
        check("pulse_back_to_back", 32'(prev_pulse && (|p)), 32'd0);
        prev_pulse = |p;
    endtask

    task automatic clr();
        n_inc = 0; n_dec = 0; n_err = 0; busy_seen = 1'b0;
    endtask

    task automatic apply(input logic a, input logic b, input int n);
        bus.SensorA = a;
        bus.SensorB = b;
        clr();
        repeat (n) tick();
    endtask

    function automatic vec_t v(input logic a, input logic b, input int i, input int d,
                               input int e, input logic bz);
        vec_t r;
        r.a = a; r.b = b; r.inc = i; r.dec = d; r.err = e; r.busy = bz;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // entry
        tbl[0]  = v(0,0,0,0,0,0); tbl[1]  = v(1,0,0,0,0,1); tbl[2]  = v(1,1,0,0,0,1);
        tbl[3]  = v(0,1,0,0,0,1); tbl[4]  = v(0,0,1,0,0,0);
        // exit
        tbl[5]  = v(0,1,0,0,0,1); tbl[6]  = v(1,1,0,0,0,1); tbl[7]  = v(1,0,0,0,0,1);
        tbl[8]  = v(0,0,0,1,0,0);
        // abort, then entry with backtracks
        tbl[9]  = v(1,0,0,0,0,1); tbl[10] = v(0,0,0,0,0,0);
        tbl[11] = v(1,0,0,0,0,1); tbl[12] = v(1,1,0,0,0,1); tbl[13] = v(0,1,0,0,0,1);
        tbl[14] = v(1,1,0,0,0,1); tbl[15] = v(0,1,0,0,0,1); tbl[16] = v(0,0,1,0,0,0);
        // illegal jump EN1->01, idle falls straight into EX1, then exit completes
        tbl[17] = v(1,0,0,0,0,1); tbl[18] = v(0,1,0,0,1,1); tbl[19] = v(1,1,0,0,0,1);
        tbl[20] = v(1,0,0,0,0,1); tbl[21] = v(0,0,0,1,0,0);
        // held 11 from idle flags once
        tbl[22] = v(1,1,0,0,1,0); tbl[23] = v(0,0,0,0,0,0);
        // EN2 -> 00 illegal
        tbl[24] = v(1,0,0,0,0,1); tbl[25] = v(1,1,0,0,0,1); tbl[26] = v(0,0,0,0,1,0);
        // EN3 -> 10 illegal, idle restarts EN1, then silent abort
        tbl[27] = v(1,0,0,0,0,1); tbl[28] = v(1,1,0,0,0,1); tbl[29] = v(0,1,0,0,0,1);
        tbl[30] = v(1,0,0,0,1,1); tbl[31] = v(0,0,0,0,0,0);
        // exit with EX2->EX1 backtrack
        tbl[32] = v(0,1,0,0,0,1); tbl[33] = v(1,1,0,0,0,1); tbl[34] = v(0,1,0,0,0,1);
        tbl[35] = v(1,1,0,0,0,1); tbl[36] = v(1,0,0,0,0,1); tbl[37] = v(0,0,0,1,0,0);

        bus.SensorA = 1'b0;
        bus.SensorB = 1'b0;
        clr();
        repeat (2) tick();
        check("reset_outputs", 32'({bus.Increase, bus.Decrease, bus.SeqError, bus.Busy}), 32'd0);
        Reset = 1'b1;
        tick();
        check("first_cycle_after_release", 32'({bus.Increase, bus.Decrease, bus.SeqError, bus.Busy}), 32'd0);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].a, tbl[i].b, HOLD);
            check($sformatf("row%0d_inc", i),  32'(n_inc), 32'(tbl[i].inc));
            check($sformatf("row%0d_dec", i),  32'(n_dec), 32'(tbl[i].dec));
            check($sformatf("row%0d_err", i),  32'(n_err), 32'(tbl[i].err));
            check($sformatf("row%0d_busy", i), 32'(bus.Busy), 32'(tbl[i].busy));
        end

        // exact Increase latency and Busy drop in the pulse cycle
        apply(1, 0, HOLD); apply(1, 1, HOLD); apply(0, 1, HOLD);
        bus.SensorA = 1'b0; bus.SensorB = 1'b0;
        for (int j = 1; j <= LAT + 2; j++) begin
            tick();
            check($sformatf("inc_lat_j%0d", j),  32'(bus.Increase), 32'(j == LAT + 1));
            check($sformatf("busy_lat_j%0d", j), 32'(bus.Busy), 32'(j < LAT + 1));
        end

        // illegal jump: SeqError cycle sits in IDLE, EX1 follows
        apply(1, 0, HOLD);
        bus.SensorA = 1'b0; bus.SensorB = 1'b1;
        for (int j = 1; j <= LAT + 2; j++) begin
            tick();
            check($sformatf("err_lat_j%0d", j), 32'(bus.SeqError), 32'(j == LAT + 1));
            if (j >= LAT + 1)
                check($sformatf("err_busy_j%0d", j), 32'(bus.Busy), 32'(j == LAT + 2));
        end
        apply(1, 1, HOLD); apply(1, 0, HOLD); apply(0, 0, HOLD);
        check("after_err_dec", 32'(n_dec), 32'd1);
        check("after_err_inc", 32'(n_inc), 32'd0);

        // asynchronous reset mid-entry, then a fresh EX1 abort
        apply(1, 0, HOLD); apply(1, 1, HOLD);
        check("mid_busy_before_reset", 32'(bus.Busy), 32'd1);
        #3;
        Reset = 1'b0;
        bus.SensorA = 1'b0; bus.SensorB = 1'b1;
        #1;
        check("async_reset_outputs", 32'({bus.Increase, bus.Decrease, bus.SeqError, bus.Busy}), 32'd0);
        clr();
        repeat (2) tick();
        Reset = 1'b1;
        apply(0, 1, HOLD);
        check("post_reset_ex1_busy", 32'(bus.Busy), 32'd1);
        check("post_reset_ex1_pulses", 32'(n_inc + n_dec + n_err), 32'd0);
        apply(0, 0, HOLD);
        check("post_reset_abort_pulses", 32'(n_inc + n_dec + n_err), 32'd0);
        check("post_reset_abort_busy", 32'(bus.Busy), 32'd0);

`ifdef GLITCH_FILTER_EN
        // 1- and 3-cycle glitches on A are swallowed
        for (int w = 1; w <= 3; w += 2) begin
            clr();
            bus.SensorA = 1'b1;
            repeat (w) tick();
            bus.SensorA = 1'b0;
            repeat (12) tick();
            check($sformatf("glitch%0d_busy", w), 32'(busy_seen), 32'd0);
            check($sformatf("glitch%0d_pulses", w), 32'(n_inc + n_dec + n_err), 32'd0);
        end
        // 5-cycle level passes: Busy rises 6 edges after the raw change
        clr();
        bus.SensorA = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 5) bus.SensorA = 1'b0;
            check($sformatf("flt_busy_j%0d", j), 32'(bus.Busy), 32'(j == 7));
        end
        apply(0, 0, 16);
        check("flt_abort_busy", 32'(bus.Busy), 32'd0);
        check("flt_abort_pulses", 32'(n_inc + n_dec + n_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
